rw_bank_scheduler: RTL and testbench



---
 rtl/rw_bank_scheduler.sv | 251 +++++++++++++++++++++++++
 tb/tb_rw_bank_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rw_bank_scheduler.sv
// rw_bank_scheduler: per-bank read/write request scheduler.
// Watermark drain modes, row-hit-first pick, burst cap, registered output.
module rw_bank_scheduler #(
   parameter int NUM_RD    = 4,
   parameter int NUM_WR    = 3,
   parameter int RA_BITS   = 16,
   parameter int IDX_BITS  = 7,
   parameter int DATA_BITS = 16,
   parameter int CNT_BITS  = 4,
   parameter int HI_WM     = 6,
   parameter int LO_WM     = 2,
   parameter int MAX_BURST = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_RD-1:0]             rd_empty,
   input  logic [NUM_WR-1:0]             wr_empty,
   input  logic [NUM_RD*RA_BITS-1:0]     rd_ra,
   input  logic [NUM_RD*IDX_BITS-1:0]    rd_idx,
   input  logic [NUM_WR*RA_BITS-1:0]     wr_ra,
   input  logic [NUM_WR*IDX_BITS-1:0]    wr_idx,
   input  logic [NUM_WR*DATA_BITS-1:0]   wr_data,
   input  logic [CNT_BITS-1:0]           wr_count,
   output logic [NUM_RD+NUM_WR-1:0]      pop,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          type_o,
   output logic [RA_BITS-1:0]            ra_o,
   output logic [IDX_BITS-1:0]           idx_o,
   output logic [DATA_BITS-1:0]          data_o,
   output logic                          mode_o
);
   localparam int RD_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
   localparam int WR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
   localparam int BC_W = $clog2(MAX_BURST + 1);
   localparam logic [RD_W-1:0]     RD_LAST = RD_W'(NUM_RD - 1);
   localparam logic [WR_W-1:0]     WR_LAST = WR_W'(NUM_WR - 1);
   localparam logic [BC_W-1:0]     BC_MAX  = BC_W'(MAX_BURST);
   localparam logic [CNT_BITS-1:0] HI_C    = CNT_BITS'(HI_WM);
   localparam logic [CNT_BITS-1:0] LO_C    = CNT_BITS'(LO_WM);

   typedef enum logic {ST_WR = 1'b0, ST_RD = 1'b1} mode_e;

   mode_e                state_q;
   mode_e                state_d;
   logic                 mode_rd;
   logic                 mode_chg;

   logic [RA_BITS-1:0]   rd_ra_a   [NUM_RD];
   logic [IDX_BITS-1:0]  rd_idx_a  [NUM_RD];
   logic [RA_BITS-1:0]   wr_ra_a   [NUM_WR];
   logic [IDX_BITS-1:0]  wr_idx_a  [NUM_WR];
   logic [DATA_BITS-1:0] wr_data_a [NUM_WR];

   logic [NUM_RD-1:0]    rd_hit_v;
   logic [NUM_WR-1:0]    wr_hit_v;
   logic                 rd_any;
   logic                 wr_any;

   logic [RD_W-1:0]      rd_rr;
   logic [RD_W-1:0]      rd_scan;
   logic [RD_W-1:0]      rd_hit_sel;
   logic [RD_W-1:0]      rd_miss_sel;
   logic [RD_W-1:0]      rd_pick;
   logic [RD_W-1:0]      rd_nxt;
   logic                 rd_hit_any;
   logic                 rd_seen;
   logic                 rd_use_hit;

   logic [WR_W-1:0]      wr_rr;
   logic [WR_W-1:0]      wr_scan;
   logic [WR_W-1:0]      wr_hit_sel;
   logic [WR_W-1:0]      wr_miss_sel;
   logic [WR_W-1:0]      wr_pick;
   logic [WR_W-1:0]      wr_nxt;
   logic                 wr_hit_any;
   logic                 wr_seen;
   logic                 wr_use_hit;

   logic [BC_W-1:0]      burst_cnt;
   logic [RA_BITS-1:0]   open_row;
   logic                 open_valid;

   logic                 load;
   logic                 sel;
   logic                 pick_hit;
   logic [RA_BITS-1:0]   pick_ra;
   logic [IDX_BITS-1:0]  pick_idx;
   logic [DATA_BITS-1:0] pick_data;
   logic [NUM_RD-1:0]    rd_pop;
   logic [NUM_WR-1:0]    wr_pop;

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      assign rd_ra_a[g]  = rd_ra[g*RA_BITS +: RA_BITS];
      assign rd_idx_a[g] = rd_idx[g*IDX_BITS +: IDX_BITS];
      assign rd_hit_v[g] = !rd_empty[g] && open_valid
                           && (rd_ra_a[g] == open_row);
   end

   for (genvar g = 0; g < NUM_WR; g++) begin : g_wr
      assign wr_ra_a[g]   = wr_ra[g*RA_BITS +: RA_BITS];
      assign wr_idx_a[g]  = wr_idx[g*IDX_BITS +: IDX_BITS];
      assign wr_data_a[g] = wr_data[g*DATA_BITS +: DATA_BITS];
      assign wr_hit_v[g]  = !wr_empty[g] && open_valid
                            && (wr_ra_a[g] == open_row);
   end

   assign rd_any = !(&rd_empty);
   assign wr_any = !(&wr_empty);

   // mode state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RD;
      else     state_q <= state_d;
   end

   // mode next state: watermark hysteresis plus idle-side fallback
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RD:
            if (wr_count >= HI_C || (!rd_any && wr_any))
               state_d = ST_WR;
         ST_WR:
            if (!wr_any || (wr_count <= LO_C && rd_any))
               state_d = ST_RD;
         default: state_d = ST_RD;
      endcase
   end

   // mode outputs
   always_comb begin
      mode_rd  = (state_q == ST_RD);
      mode_o   = mode_rd;
      mode_chg = (state_d != state_q);
   end

   // read side: first hit and first candidate in rotating order
   always_comb begin
      rd_hit_any  = 1'b0;
      rd_seen     = 1'b0;
      rd_hit_sel  = rd_rr;
      rd_miss_sel = rd_rr;
      rd_scan     = rd_rr;
      for (int k = 0; k < NUM_RD; k++) begin
         if (!rd_hit_any && rd_hit_v[rd_scan]) begin
            rd_hit_any = 1'b1;
            rd_hit_sel = rd_scan;
         end
         if (!rd_seen && !rd_empty[rd_scan]) begin
            rd_seen     = 1'b1;
            rd_miss_sel = rd_scan;
         end
         rd_scan = (rd_scan == RD_LAST) ? '0 : rd_scan + 1'b1;
      end
   end

   // write side: first hit and first candidate in rotating order
   always_comb begin
      wr_hit_any  = 1'b0;
      wr_seen     = 1'b0;
      wr_hit_sel  = wr_rr;
      wr_miss_sel = wr_rr;
      wr_scan     = wr_rr;
      for (int k = 0; k < NUM_WR; k++) begin
         if (!wr_hit_any && wr_hit_v[wr_scan]) begin
            wr_hit_any = 1'b1;
            wr_hit_sel = wr_scan;
         end
         if (!wr_seen && !wr_empty[wr_scan]) begin
            wr_seen     = 1'b1;
            wr_miss_sel = wr_scan;
         end
         wr_scan = (wr_scan == WR_LAST) ? '0 : wr_scan + 1'b1;
      end
   end

   // pick: hits win until the burst cap, then fall back to rotation
   always_comb begin
      rd_use_hit = rd_hit_any && (burst_cnt < BC_MAX);
      wr_use_hit = wr_hit_any && (burst_cnt < BC_MAX);
      rd_pick    = rd_use_hit ? rd_hit_sel : rd_miss_sel;
      wr_pick    = wr_use_hit ? wr_hit_sel : wr_miss_sel;
      rd_nxt     = (rd_pick == RD_LAST) ? '0 : rd_pick + 1'b1;
      wr_nxt     = (wr_pick == WR_LAST) ? '0 : wr_pick + 1'b1;
      load       = !valid_o || ready_i;
      sel        = !rst && load && (mode_rd ? rd_any : wr_any);
      pick_hit   = mode_rd ? rd_use_hit : wr_use_hit;
      pick_ra    = mode_rd ? rd_ra_a[rd_pick] : wr_ra_a[wr_pick];
      pick_idx   = mode_rd ? rd_idx_a[rd_pick] : wr_idx_a[wr_pick];
      pick_data  = mode_rd ? '0 : wr_data_a[wr_pick];
   end

   // one-hot pop of the selected head, only in the select cycle
   always_comb begin
      rd_pop = '0;
      wr_pop = '0;
      if (sel && mode_rd)  rd_pop[rd_pick] = 1'b1;
      if (sel && !mode_rd) wr_pop[wr_pick] = 1'b1;
   end

   assign pop = {wr_pop, rd_pop};

   // open row, burst counter and per-mode rotation pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_rr      <= '0;
         wr_rr      <= '0;
         burst_cnt  <= '0;
         open_row   <= '0;
         open_valid <= 1'b0;
      end else begin
         if (sel) begin
            if (pick_hit) begin
               if (burst_cnt != BC_MAX)
                  burst_cnt <= burst_cnt + 1'b1;
            end else begin
               open_row   <= pick_ra;
               open_valid <= 1'b1;
               burst_cnt  <= BC_W'(1);
               if (mode_rd) rd_rr <= rd_nxt;
               else         wr_rr <= wr_nxt;
            end
         end
         if (mode_chg) begin
            open_valid <= 1'b0;
            burst_cnt  <= '0;
         end
      end
   end

   // output stage: take a new request or drop valid when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_o <= 1'b0;
         type_o  <= 1'b1;
         ra_o    <= '0;
         idx_o   <= '0;
         data_o  <= '0;
      end else if (load) begin
         valid_o <= sel;
         if (sel) begin
            type_o <= mode_rd;
            ra_o   <= pick_ra;
            idx_o  <= pick_idx;
            data_o <= pick_data;
         end
      end
   end

endmodule

// File: tb/tb_rw_bank_scheduler.sv
// tb_rw_bank_scheduler: directed scoreboard bench for rw_bank_scheduler.
// FIFO heads are modelled in the bench; issued requests checked in order.
module tb_rw_bank_scheduler;
   localparam int NR  = 4;
   localparam int NW  = 3;
   localparam int RAB = 16;
   localparam int IB  = 7;
   localparam int DB  = 16;
   localparam int CB  = 4;
   localparam int NP  = NR + NW;

   typedef struct packed {
      logic          t;
      logic [RAB-1:0] ra;
      logic [IB-1:0]  idx;
      logic [DB-1:0]  data;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    rd_empty;
   logic [NW-1:0]    wr_empty;
   logic [NR*RAB-1:0] rd_ra;
   logic [NR*IB-1:0] rd_idx;
   logic [NW*RAB-1:0] wr_ra;
   logic [NW*IB-1:0] wr_idx;
   logic [NW*DB-1:0] wr_data;
   logic [CB-1:0]    wr_count;
   logic [NP-1:0]    pop;
   logic             valid_o;
   logic             ready_i;
   logic             type_o;
   logic [RAB-1:0]   ra_o;
   logic [IB-1:0]    idx_o;
   logic [DB-1:0]    data_o;
   logic             mode_o;

   logic [RAB-1:0] rd_ra_m  [NR][8];
   logic [IB-1:0]  rd_idx_m [NR][8];
   logic [RAB-1:0] wr_ra_m  [NW][8];
   logic [IB-1:0]  wr_idx_m [NW][8];
   logic [DB-1:0]  wr_dat_m [NW][8];
   int rd_hd [NR];
   int rd_tl [NR];
   int wr_hd [NW];
   int wr_tl [NW];

   exp_t exp_q [$];
   int total = 0;
   int bad   = 0;

   int bf [13] = '{0, 1, 1, 1, 1, 0, 0, 0, 2, 0, 1, 1, 0};
   int bi [13] = '{10, 20, 21, 22, 23, 11, 12, 13, 40, 14, 24, 25, 15};

   rw_bank_scheduler dut (
      .clk      (clk),
      .rst      (rst),
      .rd_empty (rd_empty),
      .wr_empty (wr_empty),
      .rd_ra    (rd_ra),
      .rd_idx   (rd_idx),
      .wr_ra    (wr_ra),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .wr_count (wr_count),
      .pop      (pop),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .type_o   (type_o),
      .ra_o     (ra_o),
      .idx_o    (idx_o),
      .data_o   (data_o),
      .mode_o   (mode_o)
   );

   always #5 clk = ~clk;

   // read FIFO heads
   always_comb begin
      rd_empty = '0;
      rd_ra    = '0;
      rd_idx   = '0;
      for (int g = 0; g < NR; g++) begin
         rd_empty[g]         = (rd_hd[g] == rd_tl[g]);
         rd_ra[g*RAB +: RAB] = rd_ra_m[g][rd_hd[g] % 8];
         rd_idx[g*IB +: IB]  = rd_idx_m[g][rd_hd[g] % 8];
      end
   end

   // write FIFO heads
   always_comb begin
      wr_empty = '0;
      wr_ra    = '0;
      wr_idx   = '0;
      wr_data  = '0;
      for (int g = 0; g < NW; g++) begin
         wr_empty[g]         = (wr_hd[g] == wr_tl[g]);
         wr_ra[g*RAB +: RAB] = wr_ra_m[g][wr_hd[g] % 8];
         wr_idx[g*IB +: IB]  = wr_idx_m[g][wr_hd[g] % 8];
         wr_data[g*DB +: DB] = wr_dat_m[g][wr_hd[g] % 8];
      end
   end

   // FIFOs advance on pop and flush on reset
   always @(posedge clk) begin
      for (int g = 0; g < NR; g++)
         if (rst)         rd_hd[g] <= rd_tl[g];
         else if (pop[g]) rd_hd[g] <= rd_hd[g] + 1;
      for (int g = 0; g < NW; g++)
         if (rst)            wr_hd[g] <= wr_tl[g];
         else if (pop[NR+g]) wr_hd[g] <= wr_hd[g] + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_rd(input int g, input logic [RAB-1:0] ra,
                          input logic [IB-1:0] idx);
      rd_ra_m[g][rd_tl[g] % 8]  = ra;
      rd_idx_m[g][rd_tl[g] % 8] = idx;
      rd_tl[g] = rd_tl[g] + 1;
   endtask

   task automatic push_wr(input int g, input logic [RAB-1:0] ra,
                          input logic [IB-1:0] idx, input logic [DB-1:0] d);
      wr_ra_m[g][wr_tl[g] % 8]  = ra;
      wr_idx_m[g][wr_tl[g] % 8] = idx;
      wr_dat_m[g][wr_tl[g] % 8] = d;
      wr_tl[g] = wr_tl[g] + 1;
   endtask

   task automatic expect_req(input logic t, input logic [RAB-1:0] ra,
                             input logic [IB-1:0] idx, input logic [DB-1:0] d);
      exp_t e;
      e.t    = t;
      e.ra   = ra;
      e.idx  = idx;
      e.data = d;
      exp_q.push_back(e);
   endtask

   function automatic logic [NP-1:0] rbit(input int g);
      logic [NP-1:0] v;
      v    = '0;
      v[g] = 1'b1;
      return v;
   endfunction

   function automatic logic [NP-1:0] wbit(input int g);
      logic [NP-1:0] v;
      v       = '0;
      v[NR+g] = 1'b1;
      return v;
   endfunction

   // settle, then check pop invariants and any accepted request
   task automatic look();
      logic [NP-1:0] empt;
      exp_t e;
      #1;
      empt = {wr_empty, rd_empty};
      chk("pop_onehot", 32'($onehot0(pop)), 1);
      chk("pop_on_empty", 32'(pop & empt), 0);
      if (mode_o) chk("pop_wr_in_rd", 32'(pop[NP-1:NR]), 0);
      else        chk("pop_rd_in_wr", 32'(pop[NR-1:0]), 0);
      if (valid_o && !ready_i) chk("pop_in_hold", 32'(pop), 0);
      if (valid_o && ready_i) begin
         chk("sb_unexpected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_type", 32'(type_o), 32'(e.t));
            chk("sb_ra", 32'(ra_o), 32'(e.ra));
            chk("sb_idx", 32'(idx_o), 32'(e.idx));
            chk("sb_data", 32'(data_o), 32'(e.data));
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(valid_o), 0);
      chk({tag, "_pop"}, 32'(pop), 0);
      chk({tag, "_type"}, 32'(type_o), 1);
      chk({tag, "_ra"}, 32'(ra_o), 0);
      chk({tag, "_idx"}, 32'(idx_o), 0);
      chk({tag, "_data"}, 32'(data_o), 0);
      chk({tag, "_mode"}, 32'(mode_o), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: run did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst      = 1'b1;
      ready_i  = 1'b0;
      wr_count = '0;
      repeat (2) @(negedge clk);
      look();
      chk_reset_vals("rst");

      @(negedge clk);
      rst     = 1'b0;
      ready_i = 1'b1;
      look();

      // single read through FIFO 2
      @(negedge clk);
      push_rd(2, 16'h0010, 7'd5);
      expect_req(1'b1, 16'h0010, 7'd5, 16'h0);
      look();
      chk("s1_pop", 32'(pop), 32'(rbit(2)));
      @(negedge clk);
      look();
      chk("s1_valid", 32'(valid_o), 1);
      chk("s1_idle_pop", 32'(pop), 0);
      @(negedge clk);
      look();
      chk("s1_drop", 32'(valid_o), 0);

      // row-hit streak with burst cap
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         push_rd(0, 16'h0AAA, 7'(10 + i));
         push_rd(1, 16'h0AAA, 7'(20 + i));
      end
      push_rd(2, 16'h0BBB, 7'd40);
      for (int c = 0; c < 13; c++) begin
         if (c > 0) @(negedge clk);
         expect_req(1'b1, (bf[c] == 2) ? 16'h0BBB : 16'h0AAA,
                    7'(bi[c]), 16'h0);
         look();
         chk("burst_pop", 32'(pop), 32'(rbit(bf[c])));
      end
      @(negedge clk);
      look();
      chk("burst_last_valid", 32'(valid_o), 1);
      @(negedge clk);
      look();
      chk("burst_drop", 32'(valid_o), 0);

      // backpressure hold
      @(negedge clk);
      push_rd(3, 16'h0123, 7'd50);
      push_rd(3, 16'h0124, 7'd51);
      expect_req(1'b1, 16'h0123, 7'd50, 16'h0);
      look();
      chk("h_pop", 32'(pop), 32'(rbit(3)));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ready_i = 1'b0;
         look();
         chk("h_valid", 32'(valid_o), 1);
         chk("h_pop0", 32'(pop), 0);
         chk("h_type", 32'(type_o), 1);
         chk("h_ra", 32'(ra_o), 32'h0123);
         chk("h_idx", 32'(idx_o), 50);
         chk("h_data", 32'(data_o), 0);
      end
      @(negedge clk);
      ready_i = 1'b1;
      expect_req(1'b1, 16'h0124, 7'd51, 16'h0);
      look();
      chk("h_resume_pop", 32'(pop), 32'(rbit(3)));
      @(negedge clk);
      look();
      @(negedge clk);
      look();
      chk("h_drop", 32'(valid_o), 0);

      // watermark drain to writes and back
      @(negedge clk);
      wr_count = 4'd5;
      for (int i = 0; i < 4; i++) push_rd(0, 16'h0200, 7'(60 + i));
      push_wr(0, 16'h0300, 7'd70, 16'hD070);
      push_wr(2, 16'h0301, 7'd71, 16'hD071);
      expect_req(1'b1, 16'h0200, 7'd60, 16'h0);
      look();
      chk("m0_mode", 32'(mode_o), 1);
      chk("m0_pop", 32'(pop), 32'(rbit(0)));
      @(negedge clk);
      wr_count = 4'd6;
      expect_req(1'b1, 16'h0200, 7'd61, 16'h0);
      look();
      chk("m1_mode", 32'(mode_o), 1);
      chk("m1_pop", 32'(pop), 32'(rbit(0)));
      @(negedge clk);
      expect_req(1'b0, 16'h0300, 7'd70, 16'hD070);
      look();
      chk("m2_mode", 32'(mode_o), 0);
      chk("m2_pop", 32'(pop), 32'(wbit(0)));
      @(negedge clk);
      wr_count = 4'd2;
      expect_req(1'b0, 16'h0301, 7'd71, 16'hD071);
      look();
      chk("m3_mode", 32'(mode_o), 0);
      chk("m3_pop", 32'(pop), 32'(wbit(2)));
      @(negedge clk);
      expect_req(1'b1, 16'h0200, 7'd62, 16'h0);
      look();
      chk("m4_mode", 32'(mode_o), 1);
      chk("m4_pop", 32'(pop), 32'(rbit(0)));
      @(negedge clk);
      expect_req(1'b1, 16'h0200, 7'd63, 16'h0);
      look();
      chk("m5_pop", 32'(pop), 32'(rbit(0)));
      @(negedge clk);
      wr_count = 4'd0;
      look();
      chk("m6_pop", 32'(pop), 0);
      @(negedge clk);
      look();
      chk("m7_drop", 32'(valid_o), 0);

      // reads empty, one write pending
      @(negedge clk);
      wr_count = 4'd1;
      push_wr(1, 16'h0400, 7'd80, 16'hBEEF);
      look();
      chk("e0_mode", 32'(mode_o), 1);
      chk("e0_pop", 32'(pop), 0);
      @(negedge clk);
      expect_req(1'b0, 16'h0400, 7'd80, 16'hBEEF);
      look();
      chk("e1_mode", 32'(mode_o), 0);
      chk("e1_pop", 32'(pop), 32'(wbit(1)));
      @(negedge clk);
      wr_count = 4'd0;
      look();
      @(negedge clk);
      look();
      chk("e3_mode", 32'(mode_o), 1);
      chk("e3_drop", 32'(valid_o), 0);

      // reset while a write is held
      @(negedge clk);
      ready_i  = 1'b0;
      wr_count = 4'd7;
      push_wr(0, 16'h0600, 7'd91, 16'h1234);
      look();
      chk("r0_mode", 32'(mode_o), 1);
      chk("r0_pop", 32'(pop), 0);
      @(negedge clk);
      look();
      chk("r1_mode", 32'(mode_o), 0);
      chk("r1_pop", 32'(pop), 32'(wbit(0)));
      @(negedge clk);
      rst = 1'b1;
      look();
      chk("r2_valid", 32'(valid_o), 1);
      chk("r2_type", 32'(type_o), 0);
      chk("r2_data", 32'(data_o), 32'h1234);
      @(negedge clk);
      wr_count = 4'd0;
      look();
      chk_reset_vals("r3");
      @(negedge clk);
      rst = 1'b0;
      look();
      chk_reset_vals("r4");

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
